node_info_engine: RTL and testbench

- Parametrised per-node state block for the EER-RL node datapath; successor to the flat combinational node-info stage.
- On each heartbeat update pulse, latches routing context (hops, cluster-head ID, timeslot) and computes normalised residual energy with a serial restoring divider.
- Applies a learning-rate Q-value update and tracks a low-energy flag with hysteresis.
- Feeds the CH-election and next-hop-selection logic through a busy/done handshake.

---
 rtl/node_info_engine_if.sv | 33 +++
 rtl/node_info_engine.sv | 157 +++++++++++++++
 tb/tb_node_info_engine.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/node_info_engine_if.sv
// rtl/node_info_engine_if.sv - heartbeat request and node-state result bundle for node_info_engine
interface node_info_engine_if #(
    parameter int WIDTH = 16
);
    logic             en_mni;
    logic [WIDTH-1:0] e_max;
    logic [WIDTH-1:0] e_min;
    logic [WIDTH-1:0] energy;
    logic [WIDTH-1:0] ch_id;
    logic [WIDTH-1:0] hops;
    logic [WIDTH-1:0] timeslot;
    logic [WIDTH-1:0] my_node_id;
    logic [WIDTH-1:0] hops_from_sink;
    logic [WIDTH-1:0] my_timeslot;
    logic [WIDTH-1:0] my_q_value;
    logic [WIDTH-1:0] norm_energy;
    logic             role;
    logic             low_e;
    logic             busy;
    logic             done;

    modport master (
        output en_mni, e_max, e_min, energy, ch_id, hops, timeslot,
        input  my_node_id, hops_from_sink, my_timeslot, my_q_value, norm_energy,
        input  role, low_e, busy, done
    );

    modport slave (
        input  en_mni, e_max, e_min, energy, ch_id, hops, timeslot,
        output my_node_id, hops_from_sink, my_timeslot, my_q_value, norm_energy,
        output role, low_e, busy, done
    );
endinterface

// File: rtl/node_info_engine.sv
// rtl/node_info_engine.sv - per-node routing context, normalised energy, Q update and low-energy flag
module node_info_engine #(
    parameter int WIDTH       = 16,
    parameter int NODE_ID     = 16'h0001,
    parameter int FRAC        = 8,
    parameter int ALPHA_SHIFT = 1,
    parameter int HOP_COST    = 16,
    parameter int HOP_MAX     = 255,
    parameter int LOW_HYST    = 50,
    parameter int Q_INIT      = 0
) (
    input  logic              clk,
    input  logic              nrst,
    node_info_engine_if.slave bus
);
    localparam int               CNT_W      = $clog2(FRAC + 1);
    localparam int               PW         = 2 * WIDTH;
    localparam int               W1         = WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAC - 1);
    localparam logic [WIDTH-1:0] NORM_ONE   = WIDTH'(2 ** FRAC);
    localparam logic [WIDTH-1:0] HOP_MAX_W  = WIDTH'(HOP_MAX);
    localparam logic [PW-1:0]    HOP_COST_W = PW'(HOP_COST);
    localparam logic [W1-1:0]    HYST_W     = W1'(LOW_HYST);
    localparam logic [WIDTH-1:0] Q_INIT_W   = WIDTH'(Q_INIT);

    typedef enum logic [1:0] {IDLE, LOAD, DIV, UPDATE} state_t;

    state_t state, state_nx;

    // Request snapshot; the live inputs may change freely once captured.
    logic [WIDTH-1:0] sh_e_max, sh_e_min, sh_energy, sh_ch_id, sh_hops, sh_timeslot;

    // Divider working state; quot also carries the clamped result from LOAD.
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] den;
    logic [WIDTH-1:0] quot;
    logic [CNT_W-1:0] cnt;

    // Committed outputs, only written in UPDATE.
    logic [WIDTH-1:0] hops_r, timeslot_r, q_val, norm_r;
    logic             role_r, low_e_r, done_r;

    logic             clamp_zero, clamp_one;
    logic [WIDTH:0]   rem_sh, rem_nx;
    logic             q_bit;
    logic [WIDTH-1:0] hops_sat, reward, q_new;
    logic [PW-1:0]    penalty;
    logic signed [WIDTH+1:0] diff, delta, q_sum;
    logic [WIDTH:0]   low_thr;

    assign clamp_zero = (sh_e_max <= sh_e_min) || (sh_energy <= sh_e_min);
    assign clamp_one  = (sh_energy >= sh_e_max);

    // remainder stays below den, so the shifted value never loses its top bit
    assign rem_sh = rem << 1;
    assign q_bit  = (rem_sh >= {1'b0, den});
    assign rem_nx = q_bit ? (rem_sh - {1'b0, den}) : rem_sh;

    assign hops_sat = (sh_hops > HOP_MAX_W) ? HOP_MAX_W : sh_hops;
    assign penalty  = {{WIDTH{1'b0}}, hops_sat} * HOP_COST_W;
    assign reward   = ({{WIDTH{1'b0}}, quot} > penalty) ? (quot - penalty[WIDTH-1:0]) : '0;
    assign diff     = $signed({2'b00, reward}) - $signed({2'b00, q_val});
    assign delta    = diff >>> ALPHA_SHIFT;
    assign q_sum    = $signed({2'b00, q_val}) + delta;
    assign q_new    = q_sum[WIDTH+1] ? '0 :
                      (q_sum > $signed({2'b00, NORM_ONE})) ? NORM_ONE : q_sum[WIDTH-1:0];
    assign low_thr  = {1'b0, sh_e_min} + HYST_W;

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state: clamped requests skip the divider entirely.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.en_mni) state_nx = LOAD;
            LOAD:    state_nx = (clamp_zero || clamp_one) ? UPDATE : DIV;
            DIV:     if (cnt == CNT_LAST) state_nx = UPDATE;
            UPDATE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: capture, divide one quotient bit per cycle, commit everything at once.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sh_e_max    <= '0;
            sh_e_min    <= '0;
            sh_energy   <= '0;
            sh_ch_id    <= '0;
            sh_hops     <= '0;
            sh_timeslot <= '0;
            rem         <= '0;
            den         <= '0;
            quot        <= '0;
            cnt         <= '0;
            hops_r      <= '0;
            timeslot_r  <= '0;
            q_val       <= Q_INIT_W;
            norm_r      <= '0;
            role_r      <= 1'b0;
            low_e_r     <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en_mni) begin
                        sh_e_max    <= bus.e_max;
                        sh_e_min    <= bus.e_min;
                        sh_energy   <= bus.energy;
                        sh_ch_id    <= bus.ch_id;
                        sh_hops     <= bus.hops;
                        sh_timeslot <= bus.timeslot;
                    end
                end
                LOAD: begin
                    cnt <= '0;
                    rem <= {1'b0, sh_energy - sh_e_min};
                    den <= sh_e_max - sh_e_min;
                    if (clamp_zero)     quot <= '0;
                    else if (clamp_one) quot <= NORM_ONE;
                    else                quot <= '0;
                end
                DIV: begin
                    cnt  <= cnt + 1'b1;
                    rem  <= rem_nx;
                    quot <= {quot[WIDTH-2:0], q_bit};
                end
                UPDATE: begin
                    hops_r     <= hops_sat;
                    timeslot_r <= sh_timeslot;
                    role_r     <= (sh_ch_id == WIDTH'(NODE_ID));
                    norm_r     <= quot;
                    q_val      <= q_new;
                    if (sh_energy < sh_e_min)                  low_e_r <= 1'b1;
                    else if ({1'b0, sh_energy} >= low_thr)     low_e_r <= 1'b0;
                    done_r     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.my_node_id     = WIDTH'(NODE_ID);
    assign bus.hops_from_sink = hops_r;
    assign bus.my_timeslot    = timeslot_r;
    assign bus.my_q_value     = q_val;
    assign bus.norm_energy    = norm_r;
    assign bus.role           = role_r;
    assign bus.low_e          = low_e_r;
    assign bus.busy           = (state != IDLE);
    assign bus.done           = done_r;
endmodule

// File: tb/tb_node_info_engine.sv
// tb/tb_node_info_engine.sv - self-checking bench for node_info_engine
module tb_node_info_engine;
    logic clk;
    logic nrst;
    node_info_engine_if #(.WIDTH(16)) bus ();

    node_info_engine dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state and last expectations
    int m_q   = 0;
    int m_low = 0;
    int exp_norm, exp_q, exp_low, exp_hops, exp_role, exp_ts, exp_lat;

    task automatic model_step(input int emax, input int emin, input int en,
                              input int ch, input int hp, input int ts);
        int norm, hs, r, d, delta, qn;
        if (emax <= emin || en <= emin) begin norm = 0; exp_lat = 2; end
        else if (en >= emax) begin norm = 256; exp_lat = 2; end
        else begin norm = (en - emin) * 256 / (emax - emin); exp_lat = 10; end
        hs = (hp > 255) ? 255 : hp;
        r  = (norm > hs * 16) ? norm - hs * 16 : 0;
        d  = r - m_q;
        delta = (d >= 0) ? d / 2 : -((-d + 1) / 2);
        qn = m_q + delta;
        if (qn < 0) qn = 0;
        if (qn > 256) qn = 256;
        m_q = qn;
        if (en < emin) m_low = 1;
        else if (en >= emin + 50) m_low = 0;
        exp_norm = norm; exp_q = qn; exp_low = m_low;
        exp_hops = hs; exp_role = (ch == 1) ? 1 : 0; exp_ts = ts;
    endtask

    task automatic drive(input int emax, input int emin, input int en,
                         input int ch, input int hp, input int ts);
        bus.e_max = 16'(emax); bus.e_min = 16'(emin); bus.energy = 16'(en);
        bus.ch_id = 16'(ch);   bus.hops  = 16'(hp);   bus.timeslot = 16'(ts);
    endtask

    task automatic run_req(input int emax, input int emin, input int en,
                           input int ch, input int hp, input int ts,
                           output int lat, output int bcnt);
        drive(emax, emin, en, ch, hp, ts);
        bus.en_mni = 1'b1;
        @(posedge clk); #1;
        bus.en_mni = 1'b0;
        lat = 0; bcnt = 0;
        while (lat < 40 && bus.done !== 1'b1) begin
            if (bus.busy === 1'b1) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        model_step(emax, emin, en, ch, hp, ts);
    endtask

    task automatic do_reset();
        nrst = 1'b0; bus.en_mni = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        m_q = 0; m_low = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.my_node_id !== 16'd1) $display("FAIL reset_node_id: got %0d want 1", bus.my_node_id); else n_pass++;
        n_checks++; if (bus.my_q_value !== 16'd0 || bus.norm_energy !== 16'd0 || bus.hops_from_sink !== 16'd0 || bus.my_timeslot !== 16'd0)
            $display("FAIL reset_values: q=%0d norm=%0d hops=%0d ts=%0d want all 0", bus.my_q_value, bus.norm_energy, bus.hops_from_sink, bus.my_timeslot);
        else n_pass++;
        n_checks++; if ({bus.role, bus.low_e, bus.busy, bus.done} !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", {bus.role, bus.low_e, bus.busy, bus.done}); else n_pass++;
    endtask

    task automatic test_divided();
        int lat, bc;
        run_req(1100, 100, 600, 5, 2, 3, lat, bc);
        n_checks++; if (lat != 10) $display("FAIL div_latency: got %0d want 10", lat); else n_pass++;
        n_checks++; if (bc != 10) $display("FAIL div_busy_cycles: got %0d want 10", bc); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL div_busy_at_done: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.norm_energy !== 16'd128) $display("FAIL div_norm: got %0d want 128", bus.norm_energy); else n_pass++;
        n_checks++; if (bus.my_q_value !== 16'd48) $display("FAIL div_q: got %0d want 48", bus.my_q_value); else n_pass++;
        n_checks++; if (bus.hops_from_sink !== 16'd2 || bus.my_timeslot !== 16'd3 || bus.role !== 1'b0 || bus.low_e !== 1'b0)
            $display("FAIL div_ctx: hops=%0d ts=%0d role=%b low=%b want 2 3 0 0", bus.hops_from_sink, bus.my_timeslot, bus.role, bus.low_e);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL div_done_pulse: got %b want 0", bus.done); else n_pass++;
    endtask

    task automatic test_clamp_high();
        int lat, bc;
        run_req(1100, 100, 1200, 1, 0, 7, lat, bc);
        n_checks++; if (lat != 2) $display("FAIL clamp_latency: got %0d want 2", lat); else n_pass++;
        n_checks++; if (bus.norm_energy !== 16'd256) $display("FAIL clamp_norm: got %0d want 256", bus.norm_energy); else n_pass++;
        n_checks++; if (bus.my_q_value !== 16'd152) $display("FAIL clamp_q: got %0d want 152", bus.my_q_value); else n_pass++;
        n_checks++; if (bus.role !== 1'b1) $display("FAIL clamp_role: got %b want 1", bus.role); else n_pass++;
    endtask

    task automatic test_hop_sat();
        int lat, bc;
        run_req(1100, 100, 600, 4, 300, 1, lat, bc);
        n_checks++; if (bus.hops_from_sink !== 16'd255) $display("FAIL hopsat_hops: got %0d want 255", bus.hops_from_sink); else n_pass++;
        n_checks++; if (bus.my_q_value !== 16'd76) $display("FAIL hopsat_q1: got %0d want 76", bus.my_q_value); else n_pass++;
        run_req(1100, 100, 600, 4, 300, 1, lat, bc);
        n_checks++; if (bus.my_q_value !== 16'd38) $display("FAIL hopsat_q2: got %0d want 38", bus.my_q_value); else n_pass++;
    endtask

    task automatic test_hysteresis();
        int lat, bc;
        int e_seq[3]    = '{90, 120, 150};
        int low_want[3] = '{1, 1, 0};
        int nrm_want[3] = '{0, 5, 12};
        for (int i = 0; i < 3; i++) begin
            run_req(1100, 100, e_seq[i], 2, 1, 0, lat, bc);
            n_checks++; if (bus.low_e !== 1'(low_want[i])) $display("FAIL hyst_low_%0d: got %b want %0d", i, bus.low_e, low_want[i]); else n_pass++;
            n_checks++; if (bus.norm_energy !== 16'(nrm_want[i])) $display("FAIL hyst_norm_%0d: got %0d want %0d", i, bus.norm_energy, nrm_want[i]); else n_pass++;
        end
        run_req(100, 100, 600, 2, 1, 0, lat, bc);
        n_checks++; if (bus.norm_energy !== 16'd0 || lat != 2) $display("FAIL degenerate: norm=%0d lat=%0d want 0 2", bus.norm_energy, lat); else n_pass++;
    endtask

    task automatic test_handshake();
        int dcnt = 0;
        int first_lat = 0;
        drive(1100, 100, 850, 1, 3, 9);
        bus.en_mni = 1'b1;
        @(posedge clk); #1;
        bus.en_mni = 1'b0;
        model_step(1100, 100, 850, 1, 3, 9);
        for (int i = 1; i <= 25; i++) begin
            if (i == 3) begin drive(1100, 100, 1300, 7, 20, 44); bus.en_mni = 1'b1; end
            @(posedge clk); #1;
            bus.en_mni = 1'b0;
            if (bus.done === 1'b1) begin dcnt++; if (dcnt == 1) first_lat = i; end
        end
        n_checks++; if (dcnt != 1 || first_lat != 10) $display("FAIL hs_single_done: dones=%0d lat=%0d want 1 10", dcnt, first_lat); else n_pass++;
        n_checks++; if (bus.norm_energy !== 16'(exp_norm) || bus.my_q_value !== 16'(exp_q) || bus.my_timeslot !== 16'(exp_ts) || bus.role !== 1'(exp_role))
            $display("FAIL hs_outputs: norm=%0d q=%0d ts=%0d role=%b want %0d %0d %0d %0d", bus.norm_energy, bus.my_q_value, bus.my_timeslot, bus.role, exp_norm, exp_q, exp_ts, exp_role);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat = 0;
        drive(1100, 100, 400, 1, 1, 2);
        bus.en_mni = 1'b1;
        @(posedge clk); #1;
        bus.en_mni = 1'b0;
        model_step(1100, 100, 400, 1, 1, 2);
        while (lat < 40 && bus.done !== 1'b1) begin @(posedge clk); #1; lat++; end
        n_checks++; if (lat != exp_lat) $display("FAIL b2b_first_lat: got %0d want %0d", lat, exp_lat); else n_pass++;
        drive(1100, 100, 1000, 3, 5, 11);
        bus.en_mni = 1'b1;
        @(posedge clk); #1;
        bus.en_mni = 1'b0;
        model_step(1100, 100, 1000, 3, 5, 11);
        lat = 0;
        while (lat < 40 && bus.done !== 1'b1) begin @(posedge clk); #1; lat++; end
        n_checks++; if (lat != exp_lat) $display("FAIL b2b_second_lat: got %0d want %0d", lat, exp_lat); else n_pass++;
        n_checks++; if (bus.norm_energy !== 16'(exp_norm) || bus.my_q_value !== 16'(exp_q) || bus.my_timeslot !== 16'(exp_ts))
            $display("FAIL b2b_outputs: norm=%0d q=%0d ts=%0d want %0d %0d %0d", bus.norm_energy, bus.my_q_value, bus.my_timeslot, exp_norm, exp_q, exp_ts);
        else n_pass++;
    endtask

    task automatic test_reset_mid_div();
        int dcnt = 0;
        int lat, bc;
        drive(1100, 100, 700, 1, 2, 5);
        bus.en_mni = 1'b1;
        @(posedge clk); #1;
        bus.en_mni = 1'b0;
        repeat (4) @(posedge clk);
        #1 nrst = 1'b0;
        #2;
        n_checks++; if (bus.my_q_value !== 16'd0 || bus.norm_energy !== 16'd0 || bus.hops_from_sink !== 16'd0 || bus.my_timeslot !== 16'd0 ||
                        {bus.role, bus.low_e, bus.busy, bus.done} !== 4'b0000)
            $display("FAIL rst_mid_outputs: q=%0d norm=%0d hops=%0d ts=%0d flags=%b want all 0", bus.my_q_value, bus.norm_energy, bus.hops_from_sink, bus.my_timeslot, {bus.role, bus.low_e, bus.busy, bus.done});
        else n_pass++;
        @(posedge clk); #1 nrst = 1'b1;
        m_q = 0; m_low = 0;
        for (int i = 0; i < 15; i++) begin @(posedge clk); #1; if (bus.done === 1'b1) dcnt++; end
        n_checks++; if (dcnt != 0 || bus.busy !== 1'b0) $display("FAIL rst_mid_no_done: dones=%0d busy=%b want 0 0", dcnt, bus.busy); else n_pass++;
        run_req(1100, 100, 600, 5, 2, 3, lat, bc);
        n_checks++; if (lat != 10 || bus.norm_energy !== 16'd128 || bus.my_q_value !== 16'd48)
            $display("FAIL rst_mid_fresh: lat=%0d norm=%0d q=%0d want 10 128 48", lat, bus.norm_energy, bus.my_q_value);
        else n_pass++;
    endtask

    task automatic test_random();
        int lat, bc, emin, emax, en, ch, hp, ts;
        for (int i = 0; i < 30; i++) begin
            emin = int'($urandom_range(0, 500));
            emax = ($urandom_range(0, 5) == 0) ? emin : int'($urandom_range(0, 1500));
            en   = int'($urandom_range(0, 1600));
            hp   = int'($urandom_range(0, 400));
            ch   = ($urandom_range(0, 1) == 1) ? 1 : int'($urandom_range(2, 9));
            ts   = int'($urandom_range(0, 65535));
            run_req(emax, emin, en, ch, hp, ts, lat, bc);
            n_checks++;
            if (lat != exp_lat || bus.norm_energy !== 16'(exp_norm) || bus.my_q_value !== 16'(exp_q) ||
                bus.low_e !== 1'(exp_low) || bus.hops_from_sink !== 16'(exp_hops) ||
                bus.role !== 1'(exp_role) || bus.my_timeslot !== 16'(exp_ts))
                $display("FAIL rand_%0d: lat=%0d norm=%0d q=%0d low=%b hops=%0d role=%b ts=%0d want %0d %0d %0d %0d %0d %0d %0d",
                         i, lat, bus.norm_energy, bus.my_q_value, bus.low_e, bus.hops_from_sink, bus.role, bus.my_timeslot,
                         exp_lat, exp_norm, exp_q, exp_low, exp_hops, exp_role, exp_ts);
            else n_pass++;
        end
    endtask

    initial begin
        nrst = 1'b0;
        bus.en_mni = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        test_reset();
        test_divided();
        test_clamp_high();
        test_hop_sat();
        test_hysteresis();
        test_handshake();
        test_back_to_back();
        test_reset_mid_div();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
